network_link_vc_arbiter: RTL

- Output-link scheduler for a NoC switch port: shares one physical flit link among NUMBEROF_VIRTUAL_CHANNELS virtual channels.
- Per-flit round-robin arbitration, gated by credit-based flow control against the downstream VC buffers.
- Tracks per-VC packet framing (header/body/tail) and flags protocol violations.
- Sits between the switch crossbar/VC buffers and the inter-router link; drives the link register.

---
 rtl/network_link_vc_arbiter_pkg.sv | 62 ++++++
 rtl/network_round_robin_arbiter.sv | 42 ++++
 rtl/network_link_vc_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/network_link_vc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// network_link_vc_arbiter_pkg
// Shared network definitions for the link VC arbiter and the switch allocators:
// default width constants, flit-type and VC framing-state enums, and the
// per-VC framing transition function.
// No ports (package).
// -----------------------------------------------------------------------------
package network_link_vc_arbiter_pkg;

    localparam int NETWORK_DEFAULT_FLIT_WIDTH                  = 64;
    localparam int NETWORK_DEFAULT_FLIT_TYPE_WIDTH             = 2;
    localparam int NETWORK_DEFAULT_NUMBEROF_VIRTUAL_CHANNELS   = 4;
    localparam int NETWORK_DEFAULT_VIRTUAL_CHANNEL_ID_WIDTH    = 3;
    localparam int NETWORK_DEFAULT_DOWNSTREAM_BUFFER_DEPTH     = 8;

    typedef enum logic [NETWORK_DEFAULT_FLIT_TYPE_WIDTH-1:0] {
        FLIT_HEADER      = 2'b00,
        FLIT_BODY        = 2'b01,
        FLIT_TAIL        = 2'b10,
        FLIT_HEADER_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        VC_IDLE      = 1'b0,
        VC_IN_PACKET = 1'b1
    } vc_state_e;

    typedef struct packed {
        vc_state_e state;
        logic      error;
    } vc_frame_t;

    // Framing transition for one accepted flit. A misplaced header still opens
    // (or closes) a packet exactly as it would from IDLE, so the stream
    // resynchronises on the offending flit.
    function automatic vc_frame_t frame_step(input vc_state_e state, input flit_type_e flit_type);
        vc_frame_t r;
        r.state = state;
        r.error = 1'b0;
        case (flit_type)
            FLIT_HEADER: begin
                r.state = VC_IN_PACKET;
                r.error = (state == VC_IN_PACKET);
            end
            FLIT_HEADER_TAIL: begin
                r.state = VC_IDLE;
                r.error = (state == VC_IN_PACKET);
            end
            FLIT_BODY: begin
                r.state = state;
                r.error = (state == VC_IDLE);
            end
            FLIT_TAIL: begin
                r.state = VC_IDLE;
                r.error = (state == VC_IDLE);
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/network_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// network_round_robin_arbiter
// Combinational round-robin picker: grants the first requester at or above
// ptr_i, wrapping modulo N. The caller owns the pointer register.
// Ports:
//   req_i        in  N      request vector
//   ptr_i        in  IDX_W  highest-priority index
//   grant_o      out N      one-hot grant (all zero when no request)
//   grant_idx_o  out IDX_W  index of the granted requester
//   any_grant_o  out 1      a grant was issued
// -----------------------------------------------------------------------------
module network_round_robin_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_grant_o
);

    logic [IDX_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        for (int off = 0; off < N; off++) begin
            idx = IDX_W'((int'(ptr_i) + off) % N);
            if (!any_grant_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/network_link_vc_arbiter.sv
// -----------------------------------------------------------------------------
// network_link_vc_arbiter
// Output-link scheduler: shares one flit link among the virtual channels with
// per-flit round-robin arbitration, credit-based flow control towards the
// downstream VC buffers, and per-VC packet framing checks.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flit_i             per-VC candidate flit (VC v is slice v)
//   flit_type_i        per-VC flit type
//   valid_i            per-VC flit available
//   ready_o            one-hot grant; flit consumed on valid_i[v] && ready_o[v]
//   credit_i           per-VC one-cycle credit-return pulse
//   flit_o/flit_type_o/vc_id_o/valid_o   registered link flit
//   protocol_error_o   sticky framing/credit error, cleared only by reset
// -----------------------------------------------------------------------------
module network_link_vc_arbiter
    import network_link_vc_arbiter_pkg::*;
#(
    parameter int NETWORK_FLIT_WIDTH                = NETWORK_DEFAULT_FLIT_WIDTH,
    parameter int NETWORK_FLIT_TYPE_WIDTH           = NETWORK_DEFAULT_FLIT_TYPE_WIDTH,
    parameter int NETWORK_NUMBEROF_VIRTUAL_CHANNELS = NETWORK_DEFAULT_NUMBEROF_VIRTUAL_CHANNELS,
    parameter int NETWORK_VIRTUAL_CHANNEL_ID_WIDTH  = NETWORK_DEFAULT_VIRTUAL_CHANNEL_ID_WIDTH,
    parameter int DOWNSTREAM_BUFFER_DEPTH           = NETWORK_DEFAULT_DOWNSTREAM_BUFFER_DEPTH
) (
    input  logic                                                            clk_i,
    input  logic                                                            rst_i,
    input  logic [NETWORK_NUMBEROF_VIRTUAL_CHANNELS*NETWORK_FLIT_WIDTH-1:0] flit_i,
    input  logic [NETWORK_NUMBEROF_VIRTUAL_CHANNELS*NETWORK_FLIT_TYPE_WIDTH-1:0] flit_type_i,
    input  logic [NETWORK_NUMBEROF_VIRTUAL_CHANNELS-1:0]                    valid_i,
    output logic [NETWORK_NUMBEROF_VIRTUAL_CHANNELS-1:0]                    ready_o,
    input  logic [NETWORK_NUMBEROF_VIRTUAL_CHANNELS-1:0]                    credit_i,
    output logic [NETWORK_FLIT_WIDTH-1:0]                                   flit_o,
    output logic [NETWORK_FLIT_TYPE_WIDTH-1:0]                              flit_type_o,
    output logic [NETWORK_VIRTUAL_CHANNEL_ID_WIDTH-1:0]                     vc_id_o,
    output logic                                                            valid_o,
    output logic                                                            protocol_error_o
);

    localparam int NVC = NETWORK_NUMBEROF_VIRTUAL_CHANNELS;
    localparam int FW  = NETWORK_FLIT_WIDTH;
    localparam int TW  = NETWORK_FLIT_TYPE_WIDTH;
    localparam int IW  = NETWORK_VIRTUAL_CHANNEL_ID_WIDTH;
    localparam int PW  = (NVC > 1) ? $clog2(NVC) : 1;
    localparam int CW  = $clog2(DOWNSTREAM_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(DOWNSTREAM_BUFFER_DEPTH);

    logic [NVC-1:0]         eligible;
    logic [NVC-1:0]         grant;
    logic [NVC-1:0]         frame_err;
    logic [NVC-1:0]         credit_ovf;
    logic [NVC-1:0][CW-1:0] vc_credit;
    logic [PW-1:0]          grant_idx;
    logic                   any_grant;

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          valid_q;
    logic [FW-1:0] flit_q;
    logic [TW-1:0] flit_type_q;
    logic [IW-1:0] vc_id_q;
    logic          error_q, error_d;

    // ---------------------------------------------------------------- per VC
    for (genvar v = 0; v < NVC; v++) begin : g_vc
        logic [CW-1:0] credit_q, credit_d;
        logic          ovf;
        vc_state_e     state_q, state_d;
        vc_frame_t     frame;
        logic          err;

        // Eligibility uses only the registered count: a returned credit takes
        // effect the cycle after its pulse.
        assign eligible[v]   = valid_i[v] && (credit_q != '0);
        assign vc_credit[v]  = credit_q;
        assign credit_ovf[v] = ovf;
        assign frame_err[v]  = err;
        assign frame         = frame_step(state_q, flit_type_e'(flit_type_i[v*TW +: TW]));

        // A grant and a credit return in the same cycle cancel out.
        always_comb begin
            credit_d = credit_q;
            ovf      = 1'b0;
            case ({grant[v], credit_i[v]})
                2'b10: credit_d = credit_q - CW'(1);
                2'b01: begin
                    if (credit_q == CREDIT_FULL) ovf = 1'b1;
                    else                         credit_d = credit_q + CW'(1);
                end
                default: ;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) credit_q <= CREDIT_FULL;
            else       credit_q <= credit_d;
        end

        // Framing FSM: state register / next state / output.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) state_q <= VC_IDLE;
            else       state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            if (grant[v]) state_d = frame.state;
        end

        always_comb begin
            err = 1'b0;
            if (grant[v]) err = frame.error;
        end
    end

    // ------------------------------------------------------------ arbitration
    network_round_robin_arbiter #(
        .N (NVC)
    ) u_rr_arb (
        .req_i       (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign ready_o = grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            if (grant_idx == PW'(NVC - 1)) rr_ptr_d = '0;
            else                           rr_ptr_d = grant_idx + PW'(1);
        end
    end

    assign error_d = error_q | (|frame_err) | (|credit_ovf);

    // ------------------------------------------------------------ link register
    // NOTE: the link payload is reset too, so the link idles at a known value
    // rather than forwarding X after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            valid_q     <= 1'b0;
            flit_q      <= '0;
            flit_type_q <= '0;
            vc_id_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= any_grant;
            error_q  <= error_d;
            if (any_grant) begin
                flit_q      <= flit_i[grant_idx*FW +: FW];
                flit_type_q <= flit_type_i[grant_idx*TW +: TW];
                vc_id_q     <= IW'(grant_idx);
            end
        end
    end

    assign valid_o          = valid_q;
    assign flit_o           = flit_q;
    assign flit_type_o      = flit_type_q;
    assign vc_id_o          = vc_id_q;
    assign protocol_error_o = error_q;

endmodule
